// File: rtl/pc_bp_btb_ras.sv
// Fetch PC unit: tagged BTB with per-entry saturating counters and entry types,
// plus a circular speculative return address stack. Lookup is combinational from pc.
module pc_bp_btb_ras #(
  parameter int W = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_BITS = 2,
  parameter int RAS_DEPTH_W = 3,
  parameter logic [W-1:0] RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] flush_addr,
  input  logic         upd_valid,
  input  logic [W-1:0] upd_pc,
  input  logic         upd_taken,
  input  logic [W-1:0] upd_target,
  input  logic [1:0]   upd_type,
  output logic [W-1:0] pc,
  output logic         pred_hit,
  output logic         pred_taken,
  output logic [W-1:0] pred_addr,
  output logic [1:0]   pred_type
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int RAS_N = 1 << RAS_DEPTH_W;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [RAS_DEPTH_W:0] RAS_FULL = (RAS_DEPTH_W + 1)'(RAS_N);
  localparam logic [1:0] T_BR   = 2'b00;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RET  = 2'b11;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic                vld_mem [DEPTH];
  logic [TAG_W-1:0]    tag_mem [DEPTH];
  logic [W-1:0]        tgt_mem [DEPTH];
  logic [1:0]          typ_mem [DEPTH];
  logic [CNT_BITS-1:0] cnt_mem [DEPTH];

  logic [W-1:0]           ras_mem [RAS_N];
  logic [RAS_DEPTH_W-1:0] ras_ptr;
  logic [RAS_DEPTH_W-1:0] ras_top_ptr;
  logic [RAS_DEPTH_W:0]   ras_cnt;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [W-1:0]     pc_inc;
  logic [W-1:0]     ras_top;
  logic             hit;
  logic             ras_nonempty;
  logic             advance;
  logic             push;
  logic             pop;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_match;

  // Address bits outside index/tag are intentionally ignored by the tables.
  logic unused_bits;
  assign unused_bits = ^{pc, upd_pc};

  assign idx          = pc[IDX_W+1:2];
  assign tag          = pc[IDX_W+TAG_W+1:IDX_W+2];
  assign pc_inc       = pc + W'(4);
  assign ras_top_ptr  = ras_ptr - 1'b1;
  assign ras_top      = ras_mem[ras_top_ptr];
  assign ras_nonempty = (ras_cnt != '0);
  assign hit          = vld_mem[idx] && (tag_mem[idx] == tag);

  always_comb begin
    pred_hit   = hit;
    pred_type  = hit ? typ_mem[idx] : T_BR;
    pred_taken = hit && ((typ_mem[idx] != T_BR) || cnt_mem[idx][CNT_BITS-1]);
    pred_addr  = pc_inc;
    if (pred_taken) begin
      if (typ_mem[idx] == T_RET && ras_nonempty) pred_addr = ras_top;
      else                                        pred_addr = tgt_mem[idx];
    end
  end

  // Speculative RAS moves only when fetch really advances along the prediction.
  assign advance = !rst && !flush && !stall;
  assign push    = advance && pred_taken && (pred_type == T_CALL);
  assign pop     = advance && pred_taken && (pred_type == T_RET) && ras_nonempty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_ADDR;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      if (flush)       pc <= flush_addr;
      else if (!stall) pc <= pred_addr;
      if (push) begin
        ras_ptr <= ras_ptr + 1'b1;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        ras_ptr <= ras_top_ptr;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= pc_inc;
  end

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_match = vld_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // A taken branch that allocates starts weakly taken instead of incrementing a stale count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_mem[i] <= 1'b0;
        cnt_mem[i] <= CNT_WNT;
      end
    end else if (upd_valid) begin
      if (upd_taken) vld_mem[upd_idx] <= 1'b1;
      if (upd_type == T_BR) begin
        if (upd_taken)      cnt_mem[upd_idx] <= upd_match ? sat_inc(cnt_mem[upd_idx]) : CNT_WT;
        else if (upd_match) cnt_mem[upd_idx] <= sat_dec(cnt_mem[upd_idx]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= upd_target;
      typ_mem[upd_idx] <= upd_type;
    end
  end

endmodule

// File: tb/tb_pc_bp_btb_ras.sv
// Vector-table bench for pc_bp_btb_ras: each vector holds the inputs for one edge and
// the outputs expected right after it; expectations pass through a scoreboard queue.
module tb_pc_bp_btb_ras;

  logic        clk = 1'b0;
  logic        rst, stall, flush, upd_valid, upd_taken;
  logic [31:0] flush_addr, upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic [31:0] pc, pred_addr;
  logic        pred_hit, pred_taken;
  logic [1:0]  pred_type;

  int checks = 0;
  int failures = 0;
  int step = 0;

  localparam logic [31:0] RADDR = 32'h700;
  localparam logic [31:0] RTGT  = 32'h7C0;

  typedef struct {
    logic rs, st, fl;
    logic [31:0] fa;
    logic uv;
    logic [31:0] upc;
    logic ut;
    logic [31:0] utg;
    logic [1:0] uty;
    logic [31:0] epc;
    logic eh, et;
    logic [31:0] ea;
    logic [1:0] ety;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];
  vec_t exp_q[$];

  pc_bp_btb_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_addr(flush_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_type(upd_type),
    .pc(pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_addr(pred_addr), .pred_type(pred_type)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic rs, logic st, logic fl, logic [31:0] fa,
                             logic uv, logic [31:0] upc, logic ut, logic [31:0] utg,
                             logic [1:0] uty, logic [31:0] epc, logic eh, logic et,
                             logic [31:0] ea, logic [1:0] ety);
    vec_t x;
    x.rs = rs; x.st = st; x.fl = fl; x.fa = fa;
    x.uv = uv; x.upc = upc; x.ut = ut; x.utg = utg; x.uty = uty;
    x.epc = epc; x.eh = eh; x.et = et; x.ea = ea; x.ety = ety;
    return x;
  endfunction

  function automatic logic [31:0] csite(int k);
    return 32'h650 + 32'(4 * k);
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step%0d_%s actual=%h required=%h", step, nm, act, req);
    end
  endtask

  task automatic check_front();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL step%0d_scoreboard actual=empty required=entry", step);
    end else begin
      e = exp_q.pop_front();
      cmp("pc", pc, e.epc);
      cmp("hit", 32'(pred_hit), 32'(e.eh));
      cmp("taken", 32'(pred_taken), 32'(e.et));
      cmp("addr", pred_addr, e.ea);
      cmp("type", 32'(pred_type), 32'(e.ety));
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are checked at the same point one edge later.
  task automatic apply(input vec_t x);
    step++;
    rst = x.rs; stall = x.st; flush = x.fl; flush_addr = x.fa;
    upd_valid = x.uv; upd_pc = x.upc; upd_taken = x.ut;
    upd_target = x.utg; upd_type = x.uty;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Free run, branch counter walk, aliasing no-op, call/return through the RAS.
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h4,  0,0,32'h8,  0));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h8,  0,0,32'hC,  0));
    tbl1.push_back(v(0,0,0,0,     1,32'h10,1,32'h80,0,   32'hC,  0,0,32'h10, 0));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h80, 0,0,32'h84, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,0,0,0,        32'h10, 1,0,32'h14, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,0,0,0,        32'h10, 1,0,32'h14, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,0,0,0,        32'h10, 1,0,32'h14, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,1,32'h80,0,   32'h10, 1,0,32'h14, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,1,32'h80,0,   32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,1,32'h80,0,   32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,1,32'h80,0,   32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,0,0,0,        32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h110,0,0,0,       32'h10, 1,1,32'h80, 0));
    tbl1.push_back(v(0,0,1,32'h10,1,32'h10,0,0,0,        32'h10, 1,0,32'h14, 0));
    tbl1.push_back(v(0,0,1,32'h40,1,32'h20,1,32'h100,2,  32'h40, 0,0,32'h44, 0));
    tbl1.push_back(v(0,0,1,32'h40,1,32'h104,1,32'h0,3,   32'h40, 0,0,32'h44, 0));
    tbl1.push_back(v(0,0,1,32'h20,0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h100,0,0,32'h104,0));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h104,1,1,32'h24, 3));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h24, 0,0,32'h28, 0));
    tbl1.push_back(v(0,0,1,32'h104,0,0,0,0,0,            32'h104,1,1,32'h0,  3));
    tbl1.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h0,  0,0,32'h4,  0));

    // Stall/flush priority, stall freezing the RAS, tag alias replacement, mid-run reset.
    tbl2.push_back(v(0,1,1,32'h200,0,0,0,0,0,            32'h200,0,0,32'h204,0));
    tbl2.push_back(v(0,0,1,32'h20,0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl2.push_back(v(0,1,0,0,     0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl2.push_back(v(0,1,0,0,     0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl2.push_back(v(0,1,0,0,     0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl2.push_back(v(0,0,1,32'h104,0,0,0,0,0,            32'h104,1,1,32'h0,  3));
    tbl2.push_back(v(0,0,1,32'h20,0,0,0,0,0,             32'h20, 1,1,32'h100,2));
    tbl2.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h100,0,0,32'h104,0));
    tbl2.push_back(v(0,0,0,0,     0,0,0,0,0,             32'h104,1,1,32'h24, 3));
    tbl2.push_back(v(0,0,1,32'h40,1,32'h10,1,32'h80,0,   32'h40, 0,0,32'h44, 0));
    tbl2.push_back(v(0,1,0,0,     1,32'h110,1,32'h300,0, 32'h40, 0,0,32'h44, 0));
    tbl2.push_back(v(0,0,1,32'h10,0,0,0,0,0,             32'h10, 0,0,32'h14, 0));
    tbl2.push_back(v(0,0,1,32'h110,0,0,0,0,0,            32'h110,1,1,32'h300,0));
    tbl2.push_back(v(1,0,1,32'h10,0,0,0,0,0,             32'h0,  0,0,32'h4,  0));
    tbl2.push_back(v(0,0,1,32'h110,0,0,0,0,0,            32'h110,0,0,32'h114,0));
    tbl2.push_back(v(0,0,1,32'h20,0,0,0,0,0,             32'h20, 0,0,32'h24, 0));
    tbl2.push_back(v(0,0,1,32'h104,0,0,0,0,0,            32'h104,0,0,32'h108,0));

    rst = 1; stall = 0; flush = 0; flush_addr = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_type = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_hit", 32'(pred_hit), 32'h0);
    cmp("rst_taken", 32'(pred_taken), 32'h0);
    cmp("rst_addr", pred_addr, 32'h4);
    cmp("rst_type", 32'(pred_type), 32'h0);

    for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i]);

    // Nine nested calls through sites C0..C8 into a return at RADDR.
    for (int k = 0; k < 9; k++)
      apply(v(0,0,1,32'h40,1,csite(k),1,(k == 8) ? RADDR : csite(k + 1),2, 32'h40,0,0,32'h44,0));
    apply(v(0,0,1,32'h40,1,RADDR,1,RTGT,3, 32'h40,0,0,32'h44,0));
    apply(v(0,0,1,csite(0),0,0,0,0,0, csite(0),1,1,csite(1),2));
    for (int k = 1; k <= 8; k++)
      apply(v(0,0,0,0,0,0,0,0,0, csite(k),1,1,(k == 8) ? RADDR : csite(k + 1),2));
    apply(v(0,0,0,0,0,0,0,0,0, RADDR,1,1,csite(9),3));
    for (int j = 0; j < 8; j++) begin
      if (j == 0)
        apply(v(0,0,0,0,0,0,0,0,0, csite(9),0,0,csite(10),0));
      else
        apply(v(0,0,0,0,0,0,0,0,0, csite(9 - j),1,1,(9 - j == 8) ? RADDR : csite(10 - j),2));
      apply(v(0,0,1,RADDR,0,0,0,0,0, RADDR,1,1,(j < 7) ? csite(8 - j) : RTGT,3));
    end
    apply(v(0,0,0,0,0,0,0,0,0, RTGT,0,0,RTGT + 32'h4,0));
    apply(v(0,0,1,RADDR,0,0,0,0,0, RADDR,1,1,RTGT,3));

    for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
